mdu_sequencer: RTL and testbench
================================

# mdu_sequencer

Multiply/divide sequencer for the five-stage pipeline. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests issued from the E stage, holds the HI/LO register pair, and models the fixed execution latency by asserting `busy` for a programmable number of cycles. The hazard unit in D stage combines `start` and `busy` to stall any multiply/divide-class instruction (including MFHI/MFLO) until the result is committed.

## Interface
- `MULT_CYCLES`, default 5: busy duration for MULT/MULTU; legal range 1..15.
- `DIV_CYCLES`, default 10: busy duration for DIV/DIVU; legal range 1..15.

- `clk`  in  1  Single clock; all state updates on the rising edge.
- `reset`  in  1  Asynchronous, active-low reset.
- `start`  in  1  Single-cycle request strobe from E stage; sampled on the rising edge.
- `op`  in  3  Operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- `a`  in  32  Operand rs (forwarded value).
- `b`  in  32  Operand rt (forwarded value).
- `busy`  out  1  High while a multiply or divide is in flight.
- `done`  out  1  One-cycle pulse in the cycle after HI/LO commit a multiply or divide result.
- `hi`  out  32  Current HI register.
- `lo`  out  32  Current LO register.

## Operation
- States: IDLE, MUL, DIV. 4-bit down-counter `cnt`. Reset state IDLE.
- IDLE, `start`=1:
  - op 1/2: latch the product into internal `res_hi`/`res_lo`, load `cnt`=MULT_CYCLES, go to MUL.
  - op 3/4: latch the quotient and remainder, load `cnt`=DIV_CYCLES, go to DIV.
  - op 5: `hi`<=`a` at this edge; remain in IDLE; `busy` stays 0.
  - op 6: `lo`<=`a` at this edge; remain in IDLE; `busy` stays 0.
  - op 0/7: no effect.
- MUL/DIV: `cnt` decrements each cycle. On the edge where `cnt`==1: `hi`<=`res_hi`, `lo`<=`res_lo`, return to IDLE. `done` is asserted in the following cycle.
- `start` in MUL/DIV is ignored: operands are not latched, HI/LO are unaffected, and `cnt` is unaffected. The hazard unit guarantees this does not occur; the bench checks that it is harmless.
- Arithmetic:
  - MULT: signed 32x32 to 64, {hi,lo} = product.
  - MULTU: unsigned 32x32 to 64, {hi,lo} = product.
  - DIV: signed. lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: unsigned. lo = quotient; hi = remainder.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (DIV or DIVU): lo=0xFFFFFFFF, hi=`a`. This is defined behaviour, not X.
- Results are computed from operands sampled at the `start` edge. Later changes on `a`/`b` have no effect.
- `busy` = (state != IDLE). It is registered state decode with no combinational path from `start`.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, `cnt`=0, state IDLE. Reset takes effect asynchronously.
- `start` sampled at edge T0 (op MULT): `busy`=1 in the cycles after edges T0..T0+MULT_CYCLES-1. At edge T0+MULT_CYCLES: `busy`=0 and new `hi`/`lo` are visible together. `done`=1 for exactly that one cycle.
- Same rule for DIV/DIVU with DIV_CYCLES.
- MTHI/MTLO: the new value is visible in the cycle after the `start` edge. Zero busy cycles, no `done`.
- Back-to-back operations: `start` may be accepted at the same edge where `busy` falls. In that case the commit and the new latch both occur at that edge. `busy` stays 1 continuously and `done` still pulses.
- MTHI or MTLO issued at the commit edge: the commit updates both registers, then the MT write overrides its target register. Net result: the MT register gets `a`; the other register gets the commit value.
- Reset asserted mid-operation aborts the operation. HI/LO return to 0, no commit occurs, and no `done` pulse is produced.

## Test plan
- Reset, then MULT with a=0xFFFFFFFE (-2), b=3 -> `busy` high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; `done` is a 1-cycle pulse.
- MULTU with a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles.
- DIV with a=-7 (0xFFFFFFF9), b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with a=7, b=0 -> lo=0xFFFFFFFF, hi=7. DIV with 0x80000000 / -1 -> lo=0x80000000, hi=0.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles -> `busy` never rises; hi=0x12345678 and lo=0x9ABCDEF0 one cycle after each respective edge.
- Start a DIV; pulse `start` with op MULT and different operands mid-flight; change `a`/`b` every cycle -> ignored: the DIV result commits at the original edge +10.
- Start a MULT; drive `reset` low at busy cycle 3 -> `busy`, `hi`, `lo`, `done` go to 0 immediately; no commit follows after release. Also a back-to-back MULT then DIV: `busy` continuous for 15 cycles, `done` pulses twice.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer: owns HI/LO, computes results at issue and commits them
// after a programmable busy window so the D-stage hazard logic can stall on it.
module mdu_sequencer #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   localparam logic [3:0] MUL_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] res_hi_q, res_hi_d;
   logic [31:0] res_lo_q, res_lo_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;

   logic        mul_signed;
   logic [63:0] mul_a, mul_b, product;
   logic        div_signed, dvd_neg, dvs_neg;
   logic [31:0] dvd_mag, dvs_mag, uquot, urem, div_q, div_r;
   logic        commit, accept;

   // One 64-bit multiplier serves both flavours; sign-extension selects MULT vs MULTU.
   always_comb begin
      mul_signed = (op == OP_MULT);
      mul_a      = {{32{mul_signed & a[31]}}, a};
      mul_b      = {{32{mul_signed & b[31]}}, b};
      product    = mul_a * mul_b;
   end

   // Signed divide runs on magnitudes; 0x80000000/-1 falls out as 0x80000000 rem 0.
   always_comb begin
      div_signed = (op == OP_DIV);
      dvd_neg    = div_signed & a[31];
      dvs_neg    = div_signed & b[31];
      dvd_mag    = dvd_neg ? (~a + 32'd1) : a;
      dvs_mag    = dvs_neg ? (~b + 32'd1) : b;
      uquot      = (dvs_mag == 32'd0) ? 32'hFFFF_FFFF : (dvd_mag / dvs_mag);
      urem       = (dvs_mag == 32'd0) ? 32'd0 : (dvd_mag % dvs_mag);
      if (b == 32'd0) begin
         div_q = 32'hFFFF_FFFF;
         div_r = a;
      end else begin
         div_q = (dvd_neg ^ dvs_neg) ? (~uquot + 32'd1) : uquot;
         div_r = dvd_neg ? (~urem + 32'd1) : urem;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;

      commit = (state_q != S_IDLE) && (cnt_q == 4'd1);
      accept = (state_q == S_IDLE) || commit;

      if (state_q != S_IDLE) begin
         cnt_d = cnt_q - 4'd1;
         if (commit) begin
            hi_d    = res_hi_q;
            lo_d    = res_lo_q;
            state_d = S_IDLE;
            done_d  = 1'b1;
         end
      end

      // A new request may land on the commit edge; MT writes then win over the commit.
      if (start && accept) begin
         case (op)
            OP_MULT, OP_MULTU: begin
               res_hi_d = product[63:32];
               res_lo_d = product[31:0];
               cnt_d    = MUL_LOAD;
               state_d  = S_MUL;
            end
            OP_DIV, OP_DIVU: begin
               res_hi_d = div_r;
               res_lo_d = div_q;
               cnt_d    = DIV_LOAD;
               state_d  = S_DIV;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         res_hi_q <= 32'd0;
         res_lo_q <= 32'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: latency, arithmetic corners, MT writes, ignored
// starts, async reset abort and back-to-back issue.
module tb_mdu_sequencer;

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int pass_cnt = 0;
   int total_cnt = 0;

   mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   // Caller sits 1 time unit after a rising edge; returns 1 unit after the issue edge.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0; op = OP_NONE;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #3;
      total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else pass_cnt++;
      total_cnt++; if (hi !== 32'd0) $display("FAIL reset_hi: got %h want 0", hi); else pass_cnt++;
      total_cnt++; if (lo !== 32'd0) $display("FAIL reset_lo: got %h want 0", lo); else pass_cnt++;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      $display("reset released: busy=%b hi=%h lo=%h", busy, hi, lo);
   endtask

   task automatic test_muldiv(input string name, input logic [2:0] o, input logic [31:0] x,
                              input logic [31:0] y, input int cycles,
                              input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      int early_done;
      n = 0; early_done = 0;
      issue(o, x, y);
      while (busy === 1'b1 && n < 40) begin
         if (done !== 1'b0) early_done++;
         @(posedge clk); #1;
         n++;
      end
      $display("%s a=%h b=%h busy_cycles=%0d hi=%h lo=%h done=%b", name, x, y, n, hi, lo, done);
      total_cnt++; if (n != cycles) $display("FAIL %s_busy_len: got %0d want %0d", name, n, cycles); else pass_cnt++;
      total_cnt++; if (early_done != 0) $display("FAIL %s_done_early: got %0d want 0", name, early_done); else pass_cnt++;
      total_cnt++; if (done !== 1'b1) $display("FAIL %s_done: got %b want 1", name, done); else pass_cnt++;
      total_cnt++; if (hi !== exp_hi) $display("FAIL %s_hi: got %h want %h", name, hi, exp_hi); else pass_cnt++;
      total_cnt++; if (lo !== exp_lo) $display("FAIL %s_lo: got %h want %h", name, lo, exp_lo); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (done !== 1'b0) $display("FAIL %s_done_width: got %b want 0", name, done); else pass_cnt++;
   endtask

   task automatic test_mthi_mtlo();
      start = 1'b1; op = OP_MTHI; a = 32'h1234_5678; b = 32'd0;
      @(posedge clk); #1;
      total_cnt++; if (hi !== 32'h1234_5678) $display("FAIL mthi_hi: got %h want 12345678", hi); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL mthi_busy: got %b want 0", busy); else pass_cnt++;
      $display("mthi a=12345678 hi=%h busy=%b", hi, busy);
      op = OP_MTLO; a = 32'h9ABC_DEF0;
      @(posedge clk); #1;
      start = 1'b0; op = OP_NONE;
      total_cnt++; if (lo !== 32'h9ABC_DEF0) $display("FAIL mtlo_lo: got %h want 9abcdef0", lo); else pass_cnt++;
      total_cnt++; if (hi !== 32'h1234_5678) $display("FAIL mtlo_hi_kept: got %h want 12345678", hi); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0) $display("FAIL mtlo_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL mtlo_done: got %b want 0", done); else pass_cnt++;
      $display("mtlo a=9abcdef0 lo=%h busy=%b", lo, busy);
      @(posedge clk); #1;
   endtask

   task automatic test_ignored_start();
      int n;
      int disturbed;
      n = 0; disturbed = 0;
      issue(OP_DIV, 32'd100, 32'd7);
      while (busy === 1'b1 && n < 40) begin
         if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) disturbed++;
         start = 1'b0; op = OP_NONE;
         a = $urandom; b = $urandom;
         if (n == 3) begin start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd6; end
         if (n == 6) begin start = 1'b1; op = OP_MTHI; a = 32'hDEAD_BEEF; end
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0; op = OP_NONE; a = 32'd0; b = 32'd0;
      $display("div_ignored a=100 b=7 busy_cycles=%0d hi=%h lo=%h done=%b", n, hi, lo, done);
      total_cnt++; if (n != 10) $display("FAIL ign_busy_len: got %0d want 10", n); else pass_cnt++;
      total_cnt++; if (disturbed != 0) $display("FAIL ign_hilo_moved: got %0d want 0", disturbed); else pass_cnt++;
      total_cnt++; if (hi !== 32'd2) $display("FAIL ign_hi: got %h want 00000002", hi); else pass_cnt++;
      total_cnt++; if (lo !== 32'd14) $display("FAIL ign_lo: got %h want 0000000e", lo); else pass_cnt++;
      total_cnt++; if (done !== 1'b1) $display("FAIL ign_done: got %b want 1", done); else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if (busy !== 1'b0) $display("FAIL ign_no_second_op: got %b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_reset_abort();
      int any_busy;
      int any_done;
      int any_val;
      any_busy = 0; any_done = 0; any_val = 0;
      issue(OP_MULT, 32'd3, 32'd4);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      $display("reset_abort: busy=%b done=%b hi=%h lo=%h", busy, done, hi, lo);
      total_cnt++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (done !== 1'b0) $display("FAIL abort_done: got %b want 0", done); else pass_cnt++;
      total_cnt++; if (hi !== 32'd0) $display("FAIL abort_hi: got %h want 0", hi); else pass_cnt++;
      total_cnt++; if (lo !== 32'd0) $display("FAIL abort_lo: got %h want 0", lo); else pass_cnt++;
      #2;
      reset = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (busy !== 1'b0) any_busy++;
         if (done !== 1'b0) any_done++;
         if (hi !== 32'd0 || lo !== 32'd0) any_val++;
      end
      total_cnt++; if (any_busy != 0) $display("FAIL abort_busy_after: got %0d want 0", any_busy); else pass_cnt++;
      total_cnt++; if (any_done != 0) $display("FAIL abort_done_after: got %0d want 0", any_done); else pass_cnt++;
      total_cnt++; if (any_val != 0) $display("FAIL abort_commit_after: got %0d want 0", any_val); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int n;
      int dn;
      logic [31:0] hi1, lo1;
      n = 0; dn = 0; hi1 = 32'hX; lo1 = 32'hX;
      issue(OP_MULT, 32'd6, 32'd7);
      while (busy === 1'b1 && n < 40) begin
         if (done === 1'b1) begin dn++; hi1 = hi; lo1 = lo; end
         start = 1'b0; op = OP_NONE;
         if (n == 4) begin start = 1'b1; op = OP_DIV; a = 32'hFFFF_FF9C; b = 32'd7; end
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0; op = OP_NONE;
      if (done === 1'b1) dn++;
      $display("b2b mult(6*7)->div(-100/7) busy_cycles=%0d dones=%0d hi=%h lo=%h", n, dn, hi, lo);
      total_cnt++; if (n != 15) $display("FAIL b2b_busy_len: got %0d want 15", n); else pass_cnt++;
      total_cnt++; if (dn != 2) $display("FAIL b2b_done_count: got %0d want 2", dn); else pass_cnt++;
      total_cnt++; if (lo1 !== 32'd42) $display("FAIL b2b_mult_lo: got %h want 0000002a", lo1); else pass_cnt++;
      total_cnt++; if (hi1 !== 32'd0) $display("FAIL b2b_mult_hi: got %h want 0", hi1); else pass_cnt++;
      total_cnt++; if (hi !== 32'hFFFF_FFFE) $display("FAIL b2b_div_hi: got %h want fffffffe", hi); else pass_cnt++;
      total_cnt++; if (lo !== 32'hFFFF_FFF2) $display("FAIL b2b_div_lo: got %h want fffffff2", lo); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_mt_at_commit();
      int n;
      n = 0;
      issue(OP_MULT, 32'd2, 32'd3);
      while (busy === 1'b1 && n < 40) begin
         start = 1'b0; op = OP_NONE;
         if (n == 4) begin start = 1'b1; op = OP_MTHI; a = 32'h0000_AAAA; end
         @(posedge clk); #1;
         n++;
      end
      start = 1'b0; op = OP_NONE;
      $display("mthi_at_commit mult(2*3) busy_cycles=%0d hi=%h lo=%h done=%b", n, hi, lo, done);
      total_cnt++; if (n != 5) $display("FAIL mtc_busy_len: got %0d want 5", n); else pass_cnt++;
      total_cnt++; if (hi !== 32'h0000_AAAA) $display("FAIL mtc_hi: got %h want 0000aaaa", hi); else pass_cnt++;
      total_cnt++; if (lo !== 32'd6) $display("FAIL mtc_lo: got %h want 00000006", lo); else pass_cnt++;
      total_cnt++; if (done !== 1'b1) $display("FAIL mtc_done: got %b want 1", done); else pass_cnt++;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_muldiv("mult_neg",   OP_MULT,  32'hFFFF_FFFE, 32'd3,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
      test_muldiv("multu_max",  OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5,  32'hFFFF_FFFE, 32'h0000_0001);
      test_muldiv("div_neg",    OP_DIV,   32'hFFFF_FFF9, 32'd2,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      test_muldiv("div_negdvs", OP_DIV,   32'd7,         32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
      test_muldiv("divu_zero",  OP_DIVU,  32'd7,         32'd0,         10, 32'h0000_0007, 32'hFFFF_FFFF);
      test_muldiv("div_ovf",    OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
      test_muldiv("divu_big",   OP_DIVU,  32'hFFFF_FFF9, 32'd2,         10, 32'h0000_0001, 32'h7FFF_FFFC);
      test_mthi_mtlo();
      test_ignored_start();
      test_mt_at_commit();
      test_back_to_back();
      test_reset_abort();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
